serial_adder_n: RTL and testbench

//   Multi-cycle, parametrised-width adder built from a chain of BPC one-bit full adders.

---
 rtl/serial_adder_n.sv | 148 ++++++++++++++
 tb/tb_serial_adder_n.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_n.sv
// Multi-cycle WIDTH-bit adder: BPC bits per clock, LSB chunk first, start/busy/done handshake.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder_n #(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int NCHUNK = (BPC > 0) ? WIDTH / BPC : 1;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    generate
        if (WIDTH < 1 || BPC < 1 || BPC > WIDTH || (WIDTH % BPC) != 0) begin : g_bad_cfg
            $error("serial_adder_n: BPC must be >= 1 and divide WIDTH exactly");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] psum_q, psum_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic [BPC:0]     c_chain;
    logic [BPC-1:0]   chunk_sum;
    logic [WIDTH-1:0] psum_shift;

    always_comb begin
        c_chain    = '0;
        chunk_sum  = '0;
        c_chain[0] = carry_q;
        for (int unsigned i = 0; i < BPC; i++) begin
            chunk_sum[i]   = a_q[i] ^ b_q[i] ^ c_chain[i];
            c_chain[i+1]   = (a_q[i] & b_q[i]) | (c_chain[i] & (a_q[i] ^ b_q[i]));
        end
        // New chunk enters at the top; after NCHUNK shifts the LSB chunk lands at bit 0.
        psum_shift = (psum_q >> BPC) | (WIDTH'(chunk_sum) << (WIDTH - BPC));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    psum_d  = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_d     = a_q >> BPC;
                b_d     = b_q >> BPC;
                carry_d = c_chain[BPC];
                psum_d  = psum_shift;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    sum_d   = psum_shift;
                    cout_d  = c_chain[BPC];
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = c_chain[BPC-1] ^ c_chain[BPC];
`endif
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // busy drops in the last RUN cycle so it is high for NCHUNK-1 cycles.
    assign busy = (state_q == S_RUN) && (cnt_q != LAST);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_n.sv
// Bench for serial_adder_n: five configurations driven with directed and random operands,
// checked against an arithmetic model {cout,sum} = a + b + cin.
module tb_serial_adder_n;

    logic clk;
    logic rst;

    logic        start_v [5];
    logic [15:0] a_v     [5];
    logic [15:0] b_v     [5];
    logic        cin_v   [5];
    logic        busy_v  [5];
    logic        done_v  [5];
    logic        cout_v  [5];
    logic        ovf_v   [5];
    logic [15:0] sum_v   [5];

    logic [7:0]  s0, s1, s4;
    logic [15:0] s2;
    logic [4:0]  s3;

    logic [15:0] prev_sum  [5];
    logic        prev_cout [5];
    logic        prev_ovf  [5];

    int wid [5] = '{8, 8, 16, 5, 8};
    int bpc [5] = '{1, 2, 4, 5, 4};

    int n_vec;
    int n_err;

    assign sum_v[0] = {8'h00, s0};
    assign sum_v[1] = {8'h00, s1};
    assign sum_v[2] = s2;
    assign sum_v[3] = {11'h000, s3};
    assign sum_v[4] = {8'h00, s4};

`ifndef SERIAL_ADDER_OVF_EN
    assign ovf_v[0] = 1'b0;
    assign ovf_v[1] = 1'b0;
    assign ovf_v[2] = 1'b0;
    assign ovf_v[3] = 1'b0;
    assign ovf_v[4] = 1'b0;
`endif

    serial_adder_n #(.WIDTH(8), .BPC(1)) u_8x1 (
        .clk(clk), .rst(rst), .start(start_v[0]), .a(a_v[0][7:0]), .b(b_v[0][7:0]),
        .cin(cin_v[0]), .busy(busy_v[0]), .done(done_v[0]), .sum(s0),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf(ovf_v[0]),
`endif
        .cout(cout_v[0]));

    serial_adder_n #(.WIDTH(8), .BPC(2)) u_8x2 (
        .clk(clk), .rst(rst), .start(start_v[1]), .a(a_v[1][7:0]), .b(b_v[1][7:0]),
        .cin(cin_v[1]), .busy(busy_v[1]), .done(done_v[1]), .sum(s1),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf(ovf_v[1]),
`endif
        .cout(cout_v[1]));

    serial_adder_n #(.WIDTH(16), .BPC(4)) u_16x4 (
        .clk(clk), .rst(rst), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]),
        .cin(cin_v[2]), .busy(busy_v[2]), .done(done_v[2]), .sum(s2),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf(ovf_v[2]),
`endif
        .cout(cout_v[2]));

    serial_adder_n #(.WIDTH(5), .BPC(5)) u_5x5 (
        .clk(clk), .rst(rst), .start(start_v[3]), .a(a_v[3][4:0]), .b(b_v[3][4:0]),
        .cin(cin_v[3]), .busy(busy_v[3]), .done(done_v[3]), .sum(s3),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf(ovf_v[3]),
`endif
        .cout(cout_v[3]));

    serial_adder_n #(.WIDTH(8), .BPC(4)) u_8x4 (
        .clk(clk), .rst(rst), .start(start_v[4]), .a(a_v[4][7:0]), .b(b_v[4][7:0]),
        .cin(cin_v[4]), .busy(busy_v[4]), .done(done_v[4]), .sum(s4),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf(ovf_v[4]),
`endif
        .cout(cout_v[4]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 5; i++) begin
            check({tag, "_busy"}, 32'(busy_v[i]), 32'd0);
            check({tag, "_done"}, 32'(done_v[i]), 32'd0);
            check({tag, "_sum"},  32'(sum_v[i]),  32'd0);
            check({tag, "_cout"}, 32'(cout_v[i]), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
            check({tag, "_ovf"},  32'(ovf_v[i]),  32'd0);
`endif
            prev_sum[i]  = '0;
            prev_cout[i] = 1'b0;
            prev_ovf[i]  = 1'b0;
        end
    endtask

    // Called at a negedge; launches one op on instance i and follows it to its done pulse.
    // hold=1 returns while done is visible so the caller can start back-to-back.
    task automatic run_op(input int i, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input bit toggle, input bit hold);
        int          n_ch;
        int          w;
        logic [16:0] mask;
        logic [16:0] full;
        logic [15:0] exp_sum;
        logic        exp_cout;
        logic        exp_ovf;
        w        = wid[i];
        n_ch     = wid[i] / bpc[i];
        mask     = (17'd1 << w) - 17'd1;
        full     = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {16'd0, c};
        exp_sum  = 16'(full & mask);
        exp_cout = full[w];
        exp_ovf  = (a[w-1] == b[w-1]) && (full[w-1] != a[w-1]);

        start_v[i] = 1'b1;
        a_v[i]     = a;
        b_v[i]     = b;
        cin_v[i]   = c;
        for (int n = 1; n <= n_ch + 1; n++) begin
            @(negedge clk);
            check("busy", 32'(busy_v[i]), 32'(n <= n_ch - 1));
            check("done", 32'(done_v[i]), 32'(n == n_ch + 1));
            if (n <= n_ch) begin
                check("sum_hold",  32'(sum_v[i]),  32'(prev_sum[i]));
                check("cout_hold", 32'(cout_v[i]), 32'(prev_cout[i]));
`ifdef SERIAL_ADDER_OVF_EN
                check("ovf_hold",  32'(ovf_v[i]),  32'(prev_ovf[i]));
`endif
            end else begin
                check("sum",  32'(sum_v[i]),  32'(exp_sum));
                check("cout", 32'(cout_v[i]), 32'(exp_cout));
`ifdef SERIAL_ADDER_OVF_EN
                check("ovf",  32'(ovf_v[i]),  32'(exp_ovf));
`endif
            end
            if (!toggle || n >= 2) start_v[i] = 1'b0;
            if (toggle) begin
                a_v[i]   = 16'($urandom);
                b_v[i]   = 16'($urandom);
                cin_v[i] = 1'($urandom);
            end
        end
        prev_sum[i]  = exp_sum;
        prev_cout[i] = exp_cout;
        prev_ovf[i]  = exp_ovf;
        if (!hold) begin
            @(negedge clk);
            check("idle_done", 32'(done_v[i]), 32'd0);
            check("idle_busy", 32'(busy_v[i]), 32'd0);
            check("idle_sum",  32'(sum_v[i]),  32'(exp_sum));
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            start_v[i] = 1'b0;
            a_v[i]     = '0;
            b_v[i]     = '0;
            cin_v[i]   = 1'b0;
        end
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        run_op(0, 16'h003C, 16'h000F, 1'b0, 1'b0, 1'b0);
        run_op(0, 16'h00FF, 16'h0000, 1'b1, 1'b0, 1'b0);
        run_op(4, 16'h007F, 16'h0001, 1'b0, 1'b0, 1'b0);
        run_op(0, 16'h003C, 16'h000F, 1'b0, 1'b0, 1'b1);
        run_op(0, 16'h0010, 16'h0020, 1'b0, 1'b0, 1'b0);
        run_op(3, 16'h001F, 16'h0001, 1'b0, 1'b0, 1'b1);
        run_op(3, 16'h0010, 16'h0010, 1'b1, 1'b0, 1'b0);
        run_op(0, 16'h00A5, 16'h005A, 1'b1, 1'b1, 1'b0);
        run_op(2, 16'hFFFF, 16'h0000, 1'b1, 1'b1, 1'b0);

        // Abort mid-run: reset in the 4th RUN cycle, no done afterwards
        start_v[0] = 1'b1;
        a_v[0]     = 16'h0055;
        b_v[0]     = 16'h0033;
        cin_v[0]   = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("abort");
        rst = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            check("abort_no_done", 32'(done_v[0]), 32'd0);
            check("abort_sum",     32'(sum_v[0]),  32'd0);
        end

        // Random sweep per configuration
        for (int cfg = 0; cfg < 4; cfg++) begin
            for (int v = 0; v < 1000; v++) begin
                run_op(cfg, 16'($urandom), 16'($urandom), 1'($urandom),
                       ($urandom_range(0, 7) == 0), 1'($urandom));
            end
        end
        for (int v = 0; v < 50; v++) begin
            run_op(4, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
